// File: rtl/forwarding_hazard_unit_pkg.sv
// forwarding_hazard_unit_pkg: select encodings, stage record and tag-match helper shared with the EX-stage forwarding muxes
package forwarding_hazard_unit_pkg;
  localparam int REG_AW = 5;
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_REG = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;
  typedef struct packed {
    logic valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic reg_write;
    logic mem_read;
  } stage_t;
  localparam stage_t BUBBLE = '0;
  // A producer writing r0 never forwards or hazards.
  function automatic logic writes(stage_t r, logic [REG_AW-1:0] tag);
    return r.valid & r.reg_write & (r.rd != '0) & (r.rd == tag);
  endfunction
endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// forwarding_hazard_unit_if: ID-side tags and control in, stall and forwarding selects out
interface forwarding_hazard_unit_if
  import forwarding_hazard_unit_pkg::*;
#(parameter int CNT_W = 16);
  logic hold;
  logic flush;
  logic id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic id_uses_rs;
  logic id_uses_rt;
  logic [REG_AW-1:0] id_rd;
  logic id_reg_write;
  logic id_mem_read;
  logic stall;
  fwd_sel_t fwd_sel_a;
  fwd_sel_t fwd_sel_b;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output hold, flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_reg_write, id_mem_read,
    input stall, fwd_sel_a, fwd_sel_b, stall_count
  );
  modport slave (
    input hold, flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_reg_write, id_mem_read,
    output stall, fwd_sel_a, fwd_sel_b, stall_count
  );
endinterface

// File: rtl/forwarding_hazard_unit_hazard_stage_reg.sv
// hazard_stage_reg: one shadow-pipeline record with async reset, hold and bubble insertion
module hazard_stage_reg
  import forwarding_hazard_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= BUBBLE;
    else if (!hold) q <= bubble ? BUBBLE : d;
endmodule

// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit: EX/MEM/WB tag tracking, forwarding select generation and load-use stall detection
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
#(parameter int CNT_W = 16)
(
  input logic clk,
  input logic rst_n,
  forwarding_hazard_unit_if.slave bus
);
  stage_t id_rec, ex, mem, wb;
  logic haz;
  logic [CNT_W-1:0] cnt;
  assign id_rec = '{valid: bus.id_valid, rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd,
                    reg_write: bus.id_reg_write, mem_read: bus.id_mem_read};
  assign haz = bus.id_valid & ex.mem_read &
               ((bus.id_uses_rs & writes(ex, bus.id_rs)) | (bus.id_uses_rt & writes(ex, bus.id_rt)));
  assign bus.stall = haz & ~bus.flush & ~bus.hold;
  hazard_stage_reg u_ex (.clk(clk), .rst_n(rst_n), .hold(bus.hold), .bubble(bus.flush | bus.stall), .d(id_rec), .q(ex));
  hazard_stage_reg u_mem (.clk(clk), .rst_n(rst_n), .hold(bus.hold), .bubble(1'b0), .d(ex), .q(mem));
  hazard_stage_reg u_wb (.clk(clk), .rst_n(rst_n), .hold(bus.hold), .bubble(1'b0), .d(mem), .q(wb));
  // Most recent producer wins; selects depend on registered records only.
  assign bus.fwd_sel_a = !ex.valid ? FWD_REG : writes(mem, ex.rs) ? FWD_EXMEM : writes(wb, ex.rs) ? FWD_MEMWB : FWD_REG;
  assign bus.fwd_sel_b = !ex.valid ? FWD_REG : writes(mem, ex.rt) ? FWD_EXMEM : writes(wb, ex.rt) ? FWD_MEMWB : FWD_REG;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (bus.stall && cnt != '1) cnt <= cnt + 1'b1;
  assign bus.stall_count = cnt;
endmodule

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Control-side companion to the EX-stage forwarding muxes. It tracks the destination/source register tags of the instructions in EX, MEM and WB in its own shadow pipeline.
- Generates the 2-bit forwarding selects consumed by the operand-A and operand-B muxes.
- Detects load-use hazards at ID and requests a one-cycle stall with bubble insertion.
- Sits between the ID stage (tag source) and the EX-stage forwarding muxes (select sink).

Parameters:
REG_AW, 5, register address width
CNT_W, 16, width of the saturating stall counter

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
hold  input  1  global pipeline freeze (memory wait); all state holds
flush  input  1  kill the instruction currently in ID (taken branch/jump)
id_valid  input  1  ID holds a real instruction
id_rs  input  REG_AW  ID source register 1
id_rt  input  REG_AW  ID source register 2
id_uses_rs  input  1  instruction reads rs
id_uses_rt  input  1  instruction reads rt
id_rd  input  REG_AW  ID destination register
id_reg_write  input  1  instruction writes rd
id_mem_read  input  1  instruction is a load
stall  output  1  freeze PC and IF/ID this cycle
fwd_sel_a  output  2  select for operand-A mux of the instruction in EX
fwd_sel_b  output  2  select for operand-B mux of the instruction in EX
stall_count  output  CNT_W  number of load-use stall cycles, saturating

Behaviour:
- Interface: single clock `clk`; reset `rst_n` is asynchronous and active-low.
- Stage record (EX, MEM, WB): {valid, rs, rt, rd, reg_write, mem_read}. Reset clears every field to 0, so stall=0, fwd_sel_a=fwd_sel_b=2'b00, stall_count=0.
- Encoding of the selects: 2'b00 = register file, 2'b10 = EX/MEM result, 2'b01 = MEM/WB result. 2'b11 is never driven.
- Advance rules, on each rising clk edge, in priority order:
  - hold=1: all records and stall_count keep their values.
  - flush=1: EX<=bubble (valid=0, rest 0), MEM<=EX, WB<=MEM.
  - stall=1: EX<=bubble, MEM<=EX, WB<=MEM.
  - Otherwise: EX<=ID record (valid=id_valid), MEM<=EX, WB<=MEM.
- A record with reg_write=1 and rd=0 is treated as non-writing: no forwarding from it and no hazard against it.
- Load-use hazard (combinational from the EX record and ID inputs):
  - haz = id_valid & EX.valid & EX.mem_read & EX.reg_write & EX.rd!=0 & ((id_uses_rs & id_rs==EX.rd) | (id_uses_rt & id_rt==EX.rd)).
  - stall = haz & ~flush & ~hold. Flush wins because the dependent instruction is being killed anyway.
  - Exactly one stall cycle per load-use pair: after the bubble, the load is in MEM and is covered by MEM/WB forwarding one cycle later.
- Forwarding, combinational from registers only (no path from ID inputs):
  - fwd_sel_a = 2'b10 if MEM.valid & MEM.reg_write & MEM.rd!=0 & MEM.rd==EX.rs.
  - Else fwd_sel_a = 2'b01 if the same condition holds for WB.
  - Else fwd_sel_a = 2'b00.
  - fwd_sel_a is forced to 2'b00 when EX.valid=0. fwd_sel_b is identical, using EX.rt.
  - MEM has priority over WB: the most recent producer wins.
  - A load in MEM matching EX is impossible by construction (bubble inserted). No special case is required; the assertion in the test plan checks it.
- stall_count increments by 1 on each edge where stall=1 and saturates at all-ones.
- Reset mid-operation clears all records immediately (asynchronous). The first post-reset cycle has no forwarding and no stall.
- Latency: selects are valid in the same cycle the instruction occupies EX. stall is valid in the same cycle the dependent instruction occupies ID.

Decomposition:
- Shared header: FWD_REG/FWD_EXMEM/FWD_MEMWB encodings (00/10/01), record field widths and bubble constant. The EX-stage forwarding muxes include the same header.
- One sub-module, hazard_stage_reg: a single record register with async reset, hold, and a load/bubble select. Instantiate it three times.
- Select priority logic and hazard compare stay in the top level.

Test Plan:
- ALU-ALU back-to-back: add r3 (rd=3, reg_write) then sub using rs=3 -> cycle the sub is in EX: fwd_sel_a=2'b10, stall=0.
- Distance-2 dependency: add r5; nop; or reading rt=5 -> fwd_sel_b=2'b01. With r5 written in both MEM and WB -> fwd_sel_b=2'b10 (MEM priority).
- Load-use: lw rd=7 then add rs=7 -> stall=1 for exactly 1 cycle; the next cycle the add is in EX with fwd_sel_a=2'b01; stall_count 0->1.
- rd=0 producer with reg_write=1 feeding rs=0 -> fwd_sel_a=2'b00, stall=0 even when the producer is a load.
- Flush and hold: load-use pair with flush=1 in the hazard cycle -> stall=0, EX bubble. hold=1 for 3 cycles mid-sequence -> selects, stall and stall_count unchanged. rst_n pulsed low mid-sequence -> all outputs 0 immediately.
- Saturation/assert: force stall_count to all-ones -> stays at all-ones after a further stall. Assert that fwd_sel never equals 2'b11 and that no load record in MEM is ever selected by a valid EX.
